// File: rtl/sample_scheduler_if.sv
//------------------------------------------------------------------------------
// sample_scheduler_if
// Codec/network bus bundle for the sample scheduler.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sample_scheduler_if #(
  parameter int W = 16
);
  logic                adc_v;
  logic signed [W-1:0] adc0;
  logic signed [W-1:0] adc1;
  logic signed [W-1:0] adc2;
  logic signed [W-1:0] adc3;

  logic                sample_clk;
  logic signed [W-1:0] sample_in0;
  logic signed [W-1:0] sample_in1;
  logic signed [W-1:0] sample_in2;
  logic signed [W-1:0] sample_in3;

  logic                net_done;
  logic signed [W-1:0] net_out0;
  logic signed [W-1:0] net_out1;
  logic signed [W-1:0] net_out2;
  logic signed [W-1:0] net_out3;

  logic signed [W-1:0] dac0;
  logic signed [W-1:0] dac1;
  logic signed [W-1:0] dac2;
  logic signed [W-1:0] dac3;
  logic                dac_v;

  logic                busy;
  logic [7:0]          n_overrun;
  logic [7:0]          n_timeout;

  modport slave (
    input  adc_v, adc0, adc1, adc2, adc3,
    input  net_done, net_out0, net_out1, net_out2, net_out3,
    output sample_clk, sample_in0, sample_in1, sample_in2, sample_in3,
    output dac0, dac1, dac2, dac3, dac_v,
    output busy, n_overrun, n_timeout
  );

  modport master (
    output adc_v, adc0, adc1, adc2, adc3,
    output net_done, net_out0, net_out1, net_out2, net_out3,
    input  sample_clk, sample_in0, sample_in1, sample_in2, sample_in3,
    input  dac0, dac1, dac2, dac3, dac_v,
    input  busy, n_overrun, n_timeout
  );
endinterface

`default_nettype wire

// File: rtl/sample_scheduler.sv
//------------------------------------------------------------------------------
// sample_scheduler
// Launches one network forward pass per codec frame and returns the result.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sample_scheduler #(
  parameter int W         = 16,
  parameter int SCLK_HIGH = 2,
  parameter int TIMEOUT   = 1024
) (
  input  wire              clk,
  input  wire              rst,
  sample_scheduler_if.slave bus
);

  localparam int c_SCLK_W = (SCLK_HIGH > 1) ? $clog2(SCLK_HIGH) : 1;
  localparam int c_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_SCLK_W-1:0] c_SCLK_LAST = c_SCLK_W'(SCLK_HIGH - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic w_accept;
  logic w_launch_end;
  logic w_capture;
  logic w_timeout;
  logic w_overrun;

  logic [c_SCLK_W-1:0] r_sclk_cnt;
  logic [c_WAIT_W-1:0] r_wait_cnt;

  logic                r_sample_clk;
  logic signed [W-1:0] r_sample_in [4];
  logic signed [W-1:0] r_dac [4];
  logic                r_dac_v;
  logic                r_busy;
  logic [7:0]          r_n_overrun;
  logic [7:0]          r_n_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // net_done is checked before the timeout so a late result still wins.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_launch_end = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_overrun    = bus.adc_v && (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (bus.adc_v) begin
          w_accept     = 1'b1;
          w_state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (r_sclk_cnt == c_SCLK_LAST) begin
          w_launch_end = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.net_done) begin
          w_capture    = 1'b1;
          w_state_next = S_CAPTURE;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_CAPTURE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_cnt   <= '0;
      r_wait_cnt   <= '0;
      r_sample_clk <= 1'b0;
      r_dac_v      <= 1'b0;
      r_busy       <= 1'b0;
      r_n_overrun  <= 8'd0;
      r_n_timeout  <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        r_sample_in[i] <= '0;
        r_dac[i]       <= '0;
      end
    end else begin
      r_busy  <= (w_state_next != S_IDLE);
      r_dac_v <= w_capture;

      if (r_state == S_LAUNCH) begin
        r_sclk_cnt <= r_sclk_cnt + 1'b1;
      end else begin
        r_sclk_cnt <= '0;
      end

      if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_accept) begin
        r_sample_clk   <= 1'b1;
        r_sample_in[0] <= bus.adc0;
        r_sample_in[1] <= bus.adc1;
        r_sample_in[2] <= bus.adc2;
        r_sample_in[3] <= bus.adc3;
      end else if (w_launch_end) begin
        r_sample_clk <= 1'b0;
      end

      if (w_capture) begin
        r_dac[0] <= bus.net_out0;
        r_dac[1] <= bus.net_out1;
        r_dac[2] <= bus.net_out2;
        r_dac[3] <= bus.net_out3;
      end

      if (w_overrun && (r_n_overrun != 8'hFF)) begin
        r_n_overrun <= r_n_overrun + 8'd1;
      end

      if (w_timeout && (r_n_timeout != 8'hFF)) begin
        r_n_timeout <= r_n_timeout + 8'd1;
      end
    end
  end

  assign bus.sample_clk = r_sample_clk;
  assign bus.sample_in0 = r_sample_in[0];
  assign bus.sample_in1 = r_sample_in[1];
  assign bus.sample_in2 = r_sample_in[2];
  assign bus.sample_in3 = r_sample_in[3];
  assign bus.dac0       = r_dac[0];
  assign bus.dac1       = r_dac[1];
  assign bus.dac2       = r_dac[2];
  assign bus.dac3       = r_dac[3];
  assign bus.dac_v      = r_dac_v;
  assign bus.busy       = r_busy;
  assign bus.n_overrun  = r_n_overrun;
  assign bus.n_timeout  = r_n_timeout;

endmodule

`default_nettype wire

// File: tb/tb_sample_scheduler.sv
//------------------------------------------------------------------------------
// tb_sample_scheduler
// Self-checking bench: vector table plus hand sequences, dac results via queue.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_sample_scheduler;

  localparam int W           = 16;
  localparam int SCLK_HIGH   = 2;
  localparam int TIMEOUT     = 16;
  localparam int SAT_TIMEOUT = 1024;
  localparam int NV          = 5;

  typedef logic [4*W-1:0] frame_t;

  typedef struct {
    frame_t adc;
    frame_t net;
    int     delay;
    bit     capture;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_scheduler_if #(.W(W)) bus ();
  sample_scheduler_if #(.W(W)) bus_sat ();

  sample_scheduler #(.W(W), .SCLK_HIGH(SCLK_HIGH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sample_scheduler #(.W(W), .SCLK_HIGH(SCLK_HIGH), .TIMEOUT(SAT_TIMEOUT)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );

  int     checks = 0;
  int     passes = 0;
  frame_t sb_q[$];
  frame_t mon_exp;
  vec_t   vecs[NV];
  frame_t exp_dac;
  int     exp_to;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t sample_frame();
    return {bus.sample_in3, bus.sample_in2, bus.sample_in1, bus.sample_in0};
  endfunction

  function automatic frame_t dac_frame();
    return {bus.dac3, bus.dac2, bus.dac1, bus.dac0};
  endfunction

  // Every dac_v must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (!rst && bus.dac_v) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_dac_v: got dac_v=1 dac=%h expected no result pending", dac_frame());
      end else begin
        mon_exp = sb_q.pop_front();
        check("dac_frame", dac_frame(), mon_exp);
      end
    end
  end

  task automatic accept_frame(input frame_t f);
    int n;
    {bus.adc3, bus.adc2, bus.adc1, bus.adc0} = f;
    bus.adc_v = 1'b1;
    tick();
    bus.adc_v = 1'b0;
    {bus.adc3, bus.adc2, bus.adc1, bus.adc0} = ~f;
    check("sample_in_latch", sample_frame(), f);
    n = 0;
    while (bus.sample_clk === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("sample_clk_high_cycles", n, SCLK_HIGH);
    check("busy_in_wait", bus.busy, 1);
  endtask

  task automatic done_pulse(input frame_t r, input bit expect_capture);
    {bus.net_out3, bus.net_out2, bus.net_out1, bus.net_out0} = r;
    bus.net_done = 1'b1;
    if (expect_capture) sb_q.push_back(r);
    tick();
    bus.net_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.adc_v = 1'b0;      bus.net_done = 1'b0;
    {bus.adc3, bus.adc2, bus.adc1, bus.adc0} = '0;
    {bus.net_out3, bus.net_out2, bus.net_out1, bus.net_out0} = '0;
    bus_sat.adc_v = 1'b0;  bus_sat.net_done = 1'b0;
    {bus_sat.adc3, bus_sat.adc2, bus_sat.adc1, bus_sat.adc0} = '0;
    {bus_sat.net_out3, bus_sat.net_out2, bus_sat.net_out1, bus_sat.net_out0} = '0;

    vecs[0] = '{adc: {16'h0004, 16'h0003, 16'h0002, 16'h1234},
                net: {16'h7FFF, 16'hFFFB, 16'h1111, 16'h0ABC}, delay: 4,  capture: 1'b1};
    vecs[1] = '{adc: {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001},
                net: {16'h0001, 16'h8000, 16'h5A5A, 16'hA5A5}, delay: 0,  capture: 1'b1};
    vecs[2] = '{adc: {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A},
                net: {16'h4444, 16'h3333, 16'h2222, 16'h1111}, delay: 15, capture: 1'b1};
    vecs[3] = '{adc: {16'h00F3, 16'h00F2, 16'h00F1, 16'h00F0},
                net: {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}, delay: 16, capture: 1'b0};
    vecs[4] = '{adc: {16'hFF00, 16'h00FF, 16'h1357, 16'h2468},
                net: {16'h0F0F, 16'hF0F0, 16'h0246, 16'h8642}, delay: 1,  capture: 1'b1};

    tick();
    tick();
    check("reset_busy", bus.busy, 0);
    check("reset_sample_clk", bus.sample_clk, 0);
    check("reset_dac_v", bus.dac_v, 0);
    check("reset_sample_in", sample_frame(), 0);
    check("reset_dac", dac_frame(), 0);
    check("reset_counters", {bus.n_overrun, bus.n_timeout}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    exp_dac = '0;
    exp_to  = 0;
    for (int i = 0; i < NV; i++) begin
      accept_frame(vecs[i].adc);
      if (vecs[i].capture) begin
        wait_n(vecs[i].delay);
        done_pulse(vecs[i].net, 1'b1);
        check("busy_in_capture", bus.busy, 1);
        check("dac_v_in_capture", bus.dac_v, 1);
        tick();
        check("busy_after_capture", bus.busy, 0);
        check("dac_v_one_cycle", bus.dac_v, 0);
        exp_dac = vecs[i].net;
      end else begin
        wait_n(TIMEOUT - 1);
        check("busy_before_timeout", bus.busy, 1);
        tick();
        check("busy_after_timeout", bus.busy, 0);
        exp_to++;
        done_pulse(vecs[i].net, 1'b0);
        check("late_done_ignored_busy", bus.busy, 0);
      end
      check("n_timeout", bus.n_timeout, exp_to);
      check("dac_hold", dac_frame(), exp_dac);
      check("sample_in_hold", sample_frame(), vecs[i].adc);
      tick();
    end

    // Overruns during WAIT and during CAPTURE.
    accept_frame({16'h0004, 16'h0003, 16'h0002, 16'h1234});
    {bus.adc3, bus.adc2, bus.adc1, bus.adc0} = {16'h7777, 16'h7777, 16'h7777, 16'h7777};
    bus.adc_v = 1'b1;
    tick();
    bus.adc_v = 1'b0;
    check("overrun_wait", bus.n_overrun, 1);
    check("overrun_sample_in", sample_frame(), {16'h0004, 16'h0003, 16'h0002, 16'h1234});
    wait_n(2);
    done_pulse({16'h0040, 16'h0030, 16'h0020, 16'h0ABC}, 1'b1);
    bus.adc_v = 1'b1;
    tick();
    bus.adc_v = 1'b0;
    check("overrun_capture", bus.n_overrun, 2);
    check("overrun_capture_busy", bus.busy, 0);
    check("overrun_capture_sample_in", sample_frame(), {16'h0004, 16'h0003, 16'h0002, 16'h1234});
    check("overrun_result", dac_frame(), {16'h0040, 16'h0030, 16'h0020, 16'h0ABC});
    tick();

    // Asynchronous reset in the middle of WAIT.
    accept_frame({16'h0001, 16'h0001, 16'h0001, 16'h0055});
    wait_n(3);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_sample_clk", bus.sample_clk, 0);
    check("rst_dac_v", bus.dac_v, 0);
    check("rst_sample_in", sample_frame(), 0);
    check("rst_dac", dac_frame(), 0);
    check("rst_counters", {bus.n_overrun, bus.n_timeout}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    accept_frame({16'h0000, 16'h0000, 16'h0000, 16'h0100});
    wait_n(2);
    done_pulse({16'h0000, 16'h0000, 16'h0000, 16'h0200}, 1'b1);
    check("post_rst_dac_v", bus.dac_v, 1);
    tick();
    check("post_rst_dac0", bus.dac0, 16'h0200);
    check("post_rst_busy", bus.busy, 0);

    // Overrun saturation on the long-timeout instance.
    {bus_sat.adc3, bus_sat.adc2, bus_sat.adc1, bus_sat.adc0} = {16'h0003, 16'h0002, 16'h0001, 16'h0055};
    bus_sat.adc_v = 1'b1;
    tick();
    wait_n(100);
    check("sat_overrun_100", bus_sat.n_overrun, 100);
    wait_n(200);
    bus_sat.adc_v = 1'b0;
    check("sat_overrun_255", bus_sat.n_overrun, 255);
    check("sat_busy", bus_sat.busy, 1);
    check("sat_sample_in", bus_sat.sample_in0, 16'h0055);

    wait_n(3);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

endmodule

`default_nettype wire

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 Parameter W, default 16: signed sample width.
REQ-002 Parameter SCLK_HIGH, default 2: cycles sample_clk is held high per frame; legal range >= 1.
REQ-003 Parameter TIMEOUT, default 1024: maximum cycles spent waiting for network completion; legal range >= 2.
REQ-004 clk  in  1  single system clock; all logic clocked on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 adc_v  in  1  one-cycle strobe: new input frame on adc0..adc3.
REQ-007 adc0..adc3  in  W each  signed input frame from codec.
REQ-008 sample_clk  out  1  registered forward-pass trigger to network.
REQ-009 sample_in0..sample_in3  out  W each  registered frame presented to network.
REQ-010 net_done  in  1  network output-valid pulse.
REQ-011 net_out0..net_out3  in  W each  network result, valid while net_done=1.
REQ-012 dac0..dac3  out  W each  registered result to codec.
REQ-013 dac_v  out  1  one-cycle strobe: dac0..dac3 just updated.
REQ-014 busy  out  1  high whenever state != IDLE.
REQ-015 n_overrun  out  8  saturating count of dropped input frames.
REQ-016 n_timeout  out  8  saturating count of frames abandoned by timeout.

Function
REQ-017 States SHALL be IDLE, LAUNCH, WAIT, CAPTURE; all outputs registered.
REQ-018 IDLE + adc_v at edge t: latch adc0..3 into sample_in0..3, set sample_clk=1, enter LAUNCH.
REQ-019 sample_clk SHALL be high exactly SCLK_HIGH consecutive cycles starting the cycle after t, then low; state enters WAIT in the same cycle sample_clk falls, wait counter=0.
REQ-020 WAIT: if net_done sampled 1, latch net_out0..3 into dac0..3, dac_v=1 next cycle (CAPTURE), return to IDLE the following cycle.
REQ-021 WAIT without net_done: counter increments each cycle; on the TIMEOUT-th WAIT cycle with no net_done, n_timeout increments (saturate 255), state returns IDLE, dac0..3 unchanged, no dac_v.
REQ-022 net_done on the TIMEOUT-th WAIT cycle SHALL take priority over timeout (result captured, no n_timeout increment).
REQ-023 net_done in any state other than WAIT SHALL be ignored.
REQ-024 adc_v in any state other than IDLE (including CAPTURE): frame dropped, sample_in0..3 unchanged, n_overrun increments (saturate 255).
REQ-025 sample_in0..3 SHALL hold stable from the latch edge until the next accepted frame.
REQ-026 dac_v SHALL be high for exactly one cycle per captured result, never otherwise.
REQ-027 Minimum accept-to-accept interval SHALL be SCLK_HIGH + 3 cycles (LAUNCH, >=1 WAIT, CAPTURE, IDLE).

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, sample_clk=0, dac_v=0, and sample_in0..3, dac0..3, n_overrun, n_timeout, wait counter to 0.
REQ-029 rst asserted mid-frame SHALL abort the frame with no dac_v; first adc_v after rst deassertion SHALL be accepted normally.

Verification (SCLK_HIGH=2, TIMEOUT=16)
REQ-030 adc_v with adc0=0x1234; net_done with net_out0=0x0ABC 5 cycles after sample_clk falls -> sample_in0=0x1234, sample_clk high exactly 2 cycles, dac0=0x0ABC, dac_v one cycle, busy low 2 cycles after net_done.
REQ-031 Second adc_v (adc0=0x7777) during WAIT -> n_overrun=1, sample_in0 stays 0x1234, result of first frame still captured.
REQ-032 No net_done after launch -> after 16 WAIT cycles n_timeout=1, busy low, dac0 unchanged, dac_v never asserted; net_done one cycle later ignored.
REQ-033 net_done on 16th WAIT cycle -> capture occurs, n_timeout unchanged.
REQ-034 rst pulse during WAIT -> all outputs 0 at once; subsequent frame adc0=0x0100, net_out0=0x0200 -> dac0=0x0200 with dac_v.
REQ-035 300 adc_v strobes while busy (net_done withheld, TIMEOUT raised) -> n_overrun saturates at 255.
